cr_vec: RTL and testbench
=========================

# cr_vec

Parametrised successor to the core's control-register / program-counter unit. Holds the PC, a small control-register file and a fetch/execute/memory-wait/interrupt-entry state machine. Generalised to PC_W-bit addresses and N_IRQ maskable, vectored interrupt lines. Sits between the decoder (branch/jump/ret strobes, register-pair data) and the fetch/memory interface.

## Interface
- PC_W, 16, PC and control-register width (8..32)
- N_IRQ, 4, interrupt line count (1..8)
- RESET_PC, 0, PC after reset
- VEC_BASE, 'h0010, address of vector 0
- VEC_SHIFT, 2, vector stride is 2^VEC_SHIFT words

Ports:
- clk  in  1  sole clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- irq  in  N_IRQ  level-sensitive interrupt requests
- mem_read, mem_write  in  1  current instruction accesses memory
- mem_ok  in  1  memory access completes this cycle
- branch  in  1  branch condition true
- bra, jmp, ret, apc  in  1  decoder strobes, valid in EXEC only
- branch_offset  in  PC_W  signed PC-relative offset
- r6_r7_data  in  PC_W  register-pair data (jump target / CR write data)
- selector  in  3  control-register select
- cr_write  in  1  write the selected CR
- pc_next  out  PC_W  registered fetch address (PC)
- cr_data  out  PC_W  combinational CR read data
- main_state  out  1  high in EXEC
- irq_ack  out  N_IRQ  one-hot, one-cycle acknowledge
- irq_active  out  1  status.in_isr

## Operation
- CRs by selector:
  - 0 STATUS: bit0 ie, bit1 in_isr
  - 1 IMASK: low N_IRQ bits
  - 2 IPEND: irq & IMASK, read-only
  - 3 EPC
  - 4 PC, read-only
  - 5–7 read 0, writes ignored
- apc high forces cr_data = PC+1 (link value) regardless of selector.
- States: FETCH → EXEC → (MEMWAIT) → FETCH or IRQ.
- FETCH: one cycle; always goes to EXEC.
- EXEC, next-PC priority: ret > jmp > (bra & branch) > PC+1.
  - ret: PC ← EPC; in_isr ← 0; ie ← 1.
  - jmp: PC ← r6_r7_data.
  - bra & branch: PC ← PC + branch_offset, mod 2^PC_W.
  - bra & !branch: PC ← PC+1.
- If (mem_read | mem_write) & !mem_ok in EXEC: go to MEMWAIT. PC and CR writes are held until the cycle with mem_ok, then committed.
- Commit point (EXEC without wait, or MEMWAIT with mem_ok):
  - If ie & !in_isr & |(irq & IMASK): go to IRQ.
  - Otherwise go to FETCH.
- IRQ (one cycle):
  - k = lowest set index of irq & IMASK, sampled at the commit point.
  - EPC ← committed PC; PC ← VEC_BASE + (k << VEC_SHIFT).
  - ie ← 0; in_isr ← 1; irq_ack[k] = 1; next state FETCH.
- No nesting: in_isr blocks entry until ret.
- Simultaneous events:
  - ret and cr_write to EPC in the same cycle: ret uses the old EPC.
  - cr_write to STATUS committing together with IRQ entry: IRQ's ie/in_isr values win.
  - ret with a pending enabled irq: commit, then IRQ on the next cycle (back-to-back).
  - Strobes outside EXEC/MEMWAIT are ignored.
- Reset (any state, including mid-MEMWAIT):
  - PC = RESET_PC; EPC, IMASK, STATUS = 0; state FETCH.
  - irq_ack = 0; main_state = 0; irq_active = 0.
  - cr_data reflects these values (STATUS = 0 after reset).

## Timing
- pc_next, STATUS, IMASK, EPC and state are registered.
- cr_data and IPEND are combinational from registers plus irq.
- CR writes are visible on cr_data the cycle after commit.
- Instruction without memory: 2 cycles (FETCH, EXEC). Memory wait adds one cycle per cycle mem_ok is low.
- Interrupt entry adds 1 cycle. Vector fetch starts 1 cycle after the commit point.
- irq_ack is high exactly the IRQ cycle.
- irq is sampled only at the commit point. A line dropped before that point is never acknowledged.

## Structure
- Package cr_vec_pkg holds:
  - state enum FETCH/EXEC/MEMWAIT/IRQ
  - selector codes CR_STATUS..CR_PC
  - STATUS bit indices IE_BIT and ISR_BIT
- Sub-module irq_prio_enc: N_IRQ-parametrised lowest-index priority encoder with outputs valid, index and one-hot.

## Test plan
- Reset, then 3 plain instructions: pc_next 0→1→2→3; main_state toggles 0,1; cr_data (sel 0) = 0.
- jmp with r6_r7_data='h1234 → pc_next='h1234. bra & branch, PC='h0002, offset='hFFFC → 'hFFFE (wrap). bra & !branch → PC+1.
- mem_read with mem_ok low 3 cycles: main_state low during wait, PC frozen; commit on the mem_ok cycle.
- IMASK='b1010, ie=1, irq='b1110 at commit with next PC 'h0040:
  - IRQ cycle: irq_ack='b0010; EPC='h0040; pc_next='h0014.
  - Next cycle: irq_active=1.
  - Later ret → PC='h0040, ie=1.
- ret while irq[3] pending and enabled: PC → EPC, then IRQ entry immediately; irq_ack='b1000.
- Assert reset during MEMWAIT with PC='h0100: all outputs return to reset values immediately, asynchronously, without a clock edge.

Source files
------------

// File: rtl/cr_vec_pkg.sv
// Shared types and constants for the control-register / PC unit.
package cr_vec_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXEC    = 2'd1,
    MEMWAIT = 2'd2,
    IRQ     = 2'd3
  } state_e;

  localparam logic [2:0] CR_STATUS = 3'd0;
  localparam logic [2:0] CR_IMASK  = 3'd1;
  localparam logic [2:0] CR_IPEND  = 3'd2;
  localparam logic [2:0] CR_EPC    = 3'd3;
  localparam logic [2:0] CR_PC     = 3'd4;

  localparam int IE_BIT  = 0;
  localparam int ISR_BIT = 1;

  // Index width covers the maximum of eight interrupt lines.
  localparam int IDX_W = 3;

endpackage

// File: rtl/cr_vec_irq_prio_enc.sv
// Lowest-index-wins priority encoder for the masked interrupt lines.
module irq_prio_enc
  import cr_vec_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] index,
  output logic [N-1:0]     onehot
);

  // Scan from the top so the lowest set line is the last to overwrite.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        index = IDX_W'(i);
      end else begin
        valid = valid;
      end
    end
  end

  // Expand the selected index into a one-hot acknowledge pattern.
  always_comb begin
    if (valid) begin
      onehot = N'(1) << index;
    end else begin
      onehot = '0;
    end
  end

endmodule

// File: rtl/cr_vec.sv
// PC, control-register file and fetch/exec/memwait/irq sequencer with
// vectored, maskable, non-nesting interrupts.
module cr_vec
  import cr_vec_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter int              N_IRQ     = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [PC_W-1:0] VEC_BASE  = PC_W'(16'h0010),
  parameter int              VEC_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             mem_ok,
  input  logic             branch,
  input  logic             bra,
  input  logic             jmp,
  input  logic             ret,
  input  logic             apc,
  input  logic [PC_W-1:0]  branch_offset,
  input  logic [PC_W-1:0]  r6_r7_data,
  input  logic [2:0]       selector,
  input  logic             cr_write,
  output logic [PC_W-1:0]  pc_next,
  output logic [PC_W-1:0]  cr_data,
  output logic             main_state,
  output logic [N_IRQ-1:0] irq_ack,
  output logic             irq_active
);

  state_e            state_r, state_nxt_s;
  logic [PC_W-1:0]   pc_r, pc_nxt_s, epc_r, epc_nxt_s;
  logic [PC_W-1:0]   pc_inc_s, target_s, vec_addr_s;
  logic [N_IRQ-1:0]  imask_r, imask_nxt_s, ipend_s;
  logic [N_IRQ-1:0]  ack_r, ack_nxt_s, pend_onehot_s;
  logic [1:0]        status_r, status_nxt_s, status_commit_s;
  logic              main_state_r;
  logic              pend_valid_s;
  logic [IDX_W-1:0]  pend_idx_s;
  logic              active_s, commit_s, take_irq_s, mem_s;

  assign ipend_s     = irq & imask_r;
  assign pc_inc_s    = pc_r + PC_W'(1);
  assign vec_addr_s  = VEC_BASE + (PC_W'(pend_idx_s) << VEC_SHIFT);
  assign active_s    = (state_r == EXEC) || (state_r == MEMWAIT);
  assign mem_s       = mem_read | mem_write;

  irq_prio_enc #(.N(N_IRQ)) u_prio (
    .req    (ipend_s),
    .valid  (pend_valid_s),
    .index  (pend_idx_s),
    .onehot (pend_onehot_s)
  );

  // Commit happens in EXEC without a stall, or in MEMWAIT once mem_ok arrives.
  always_comb begin
    case (state_r)
      EXEC:    commit_s = !(mem_s && !mem_ok);
      MEMWAIT: commit_s = mem_ok;
      default: commit_s = 1'b0;
    endcase
  end

  // Next-PC priority: ret > jmp > taken branch > sequential.
  always_comb begin
    if (ret) begin
      target_s = epc_r;
    end else if (jmp) begin
      target_s = r6_r7_data;
    end else if (bra && branch) begin
      target_s = pc_r + branch_offset;
    end else begin
      target_s = pc_inc_s;
    end
  end

  // STATUS as it would be after this commit; the IRQ decision looks at it so
  // a ret with a pending line enters the handler back-to-back.
  always_comb begin
    status_commit_s = status_r;
    if (cr_write && (selector == CR_STATUS)) begin
      status_commit_s = r6_r7_data[1:0];
    end else begin
      status_commit_s = status_r;
    end
    if (ret) begin
      status_commit_s[IE_BIT]  = 1'b1;
      status_commit_s[ISR_BIT] = 1'b0;
    end else begin
      status_commit_s = status_commit_s;
    end
  end

  assign take_irq_s = commit_s && status_commit_s[IE_BIT]
                    && !status_commit_s[ISR_BIT] && pend_valid_s;

  // Sequencer and register-file next values; IRQ entry overrides CR writes.
  always_comb begin
    state_nxt_s  = state_r;
    pc_nxt_s     = pc_r;
    epc_nxt_s    = epc_r;
    imask_nxt_s  = imask_r;
    status_nxt_s = status_r;
    ack_nxt_s    = '0;
    case (state_r)
      FETCH: begin
        state_nxt_s = EXEC;
      end
      EXEC, MEMWAIT: begin
        if (commit_s) begin
          pc_nxt_s     = target_s;
          status_nxt_s = status_commit_s;
          if (cr_write && (selector == CR_IMASK)) begin
            imask_nxt_s = r6_r7_data[N_IRQ-1:0];
          end else begin
            imask_nxt_s = imask_r;
          end
          if (cr_write && (selector == CR_EPC)) begin
            epc_nxt_s = r6_r7_data;
          end else begin
            epc_nxt_s = epc_r;
          end
          if (take_irq_s) begin
            epc_nxt_s             = target_s;
            pc_nxt_s              = vec_addr_s;
            status_nxt_s[IE_BIT]  = 1'b0;
            status_nxt_s[ISR_BIT] = 1'b1;
            ack_nxt_s             = pend_onehot_s;
            state_nxt_s           = IRQ;
          end else begin
            state_nxt_s = FETCH;
          end
        end else begin
          state_nxt_s = MEMWAIT;
        end
      end
      IRQ: begin
        state_nxt_s = FETCH;
      end
      default: begin
        state_nxt_s = FETCH;
      end
    endcase
  end

  // Architectural state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= FETCH;
      pc_r         <= RESET_PC;
      epc_r        <= '0;
      imask_r      <= '0;
      status_r     <= 2'b00;
      ack_r        <= '0;
      main_state_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      epc_r        <= epc_nxt_s;
      imask_r      <= imask_nxt_s;
      status_r     <= status_nxt_s;
      ack_r        <= ack_nxt_s;
      main_state_r <= (state_nxt_s == EXEC);
    end
  end

  // CR read mux; apc overrides the selector with the link value.
  always_comb begin
    if (apc && active_s) begin
      cr_data = pc_inc_s;
    end else begin
      case (selector)
        CR_STATUS: cr_data = {{(PC_W-2){1'b0}}, status_r};
        CR_IMASK:  cr_data = PC_W'(imask_r);
        CR_IPEND:  cr_data = PC_W'(ipend_s);
        CR_EPC:    cr_data = epc_r;
        CR_PC:     cr_data = pc_r;
        default:   cr_data = '0;
      endcase
    end
  end

  assign pc_next    = pc_r;
  assign main_state = main_state_r;
  assign irq_ack    = ack_r;
  assign irq_active = status_r[ISR_BIT];

endmodule

// File: tb/tb_cr_vec.sv
// Directed bench for cr_vec with hand-computed expectations.
module tb_cr_vec;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq;
  logic        mem_read, mem_write, mem_ok;
  logic        branch, bra, jmp, ret, apc;
  logic [15:0] branch_offset, r6_r7_data;
  logic [2:0]  selector;
  logic        cr_write;
  logic [15:0] pc_next, cr_data;
  logic        main_state;
  logic [3:0]  irq_ack;
  logic        irq_active;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cr_vec dut (
    .clk(clk), .rst(rst), .irq(irq),
    .mem_read(mem_read), .mem_write(mem_write), .mem_ok(mem_ok),
    .branch(branch), .bra(bra), .jmp(jmp), .ret(ret), .apc(apc),
    .branch_offset(branch_offset), .r6_r7_data(r6_r7_data),
    .selector(selector), .cr_write(cr_write),
    .pc_next(pc_next), .cr_data(cr_data), .main_state(main_state),
    .irq_ack(irq_ack), .irq_active(irq_active)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr();
    step();
    step();
  endtask

  task automatic rd_cr(input logic [2:0] sel, input logic [15:0] exp, input string tag);
    selector = sel;
    #1;
    check_eq(tag, {16'h0, cr_data}, {16'h0, exp});
  endtask

  initial begin
    rst = 1'b0; irq = 4'b0000;
    mem_read = 1'b0; mem_write = 1'b0; mem_ok = 1'b0;
    branch = 1'b0; bra = 1'b0; jmp = 1'b0; ret = 1'b0; apc = 1'b0;
    branch_offset = 16'h0000; r6_r7_data = 16'h0000;
    selector = 3'd0; cr_write = 1'b0;
    #2;
    check_eq("rst_pc", {16'h0, pc_next}, 32'h0);
    check_eq("rst_ms", {31'h0, main_state}, 32'h0);
    check_eq("rst_ack", {28'h0, irq_ack}, 32'h0);
    check_eq("rst_isr", {31'h0, irq_active}, 32'h0);
    rd_cr(3'd0, 16'h0000, "rst_status");
    #9 rst = 1'b1;

    // three plain instructions
    for (int i = 1; i <= 3; i++) begin
      step();
      check_eq("plain_ms_exec", {31'h0, main_state}, 32'h1);
      step();
      check_eq("plain_pc", {16'h0, pc_next}, i);
      check_eq("plain_ms_fetch", {31'h0, main_state}, 32'h0);
    end

    jmp = 1'b1; r6_r7_data = 16'h1234;
    run_instr();
    check_eq("jmp_pc", {16'h0, pc_next}, 32'h1234);
    r6_r7_data = 16'h0002;
    run_instr();
    jmp = 1'b0;
    check_eq("jmp_pc2", {16'h0, pc_next}, 32'h0002);
    bra = 1'b1; branch = 1'b1; branch_offset = 16'hFFFC;
    run_instr();
    check_eq("bra_wrap", {16'h0, pc_next}, 32'hFFFE);
    branch = 1'b0;
    run_instr();
    check_eq("bra_not_taken", {16'h0, pc_next}, 32'hFFFF);
    bra = 1'b0;
    run_instr();
    check_eq("pc_wrap", {16'h0, pc_next}, 32'h0000);

    // memory wait with an IMASK write held until mem_ok
    mem_read = 1'b1; mem_ok = 1'b0; cr_write = 1'b1; selector = 3'd1; r6_r7_data = 16'h000A;
    step();
    step();
    check_eq("mw_ms", {31'h0, main_state}, 32'h0);
    check_eq("mw_pc", {16'h0, pc_next}, 32'h0);
    check_eq("mw_imask_held", {16'h0, cr_data}, 32'h0);
    step();
    step();
    check_eq("mw_pc_frozen", {16'h0, pc_next}, 32'h0);
    mem_ok = 1'b1;
    step();
    check_eq("mw_commit_pc", {16'h0, pc_next}, 32'h1);
    check_eq("mw_imask", {16'h0, cr_data}, 32'h000A);
    mem_read = 1'b0; mem_ok = 1'b0; cr_write = 1'b0;

    // enable interrupts
    cr_write = 1'b1; selector = 3'd0; r6_r7_data = 16'h0001;
    run_instr();
    cr_write = 1'b0;
    rd_cr(3'd0, 16'h0001, "status_ie");
    irq = 4'b1111;
    rd_cr(3'd2, 16'h000A, "ipend");
    rd_cr(3'd4, 16'h0002, "cr_pc");
    rd_cr(3'd5, 16'h0000, "cr_unused");

    // IRQ entry at commit with next PC 0x0040
    irq = 4'b1110; jmp = 1'b1; r6_r7_data = 16'h0040; selector = 3'd3;
    step();
    step();
    check_eq("irq_ack", {28'h0, irq_ack}, 32'h2);
    check_eq("irq_vec", {16'h0, pc_next}, 32'h0014);
    check_eq("irq_epc", {16'h0, cr_data}, 32'h0040);
    jmp = 1'b0; irq = 4'b0000;
    step();
    check_eq("ack_one_cycle", {28'h0, irq_ack}, 32'h0);
    check_eq("irq_active", {31'h0, irq_active}, 32'h1);

    // handler instruction: apc link value, pending irq blocked by in_isr
    irq = 4'b0010; apc = 1'b1;
    step();
    check_eq("apc_link", {16'h0, cr_data}, 32'h0015);
    apc = 1'b0;
    step();
    check_eq("no_nest_ack", {28'h0, irq_ack}, 32'h0);
    check_eq("no_nest_pc", {16'h0, pc_next}, 32'h0015);

    // ret with irq[3] pending: back-to-back entry
    irq = 4'b1000; ret = 1'b1;
    run_instr();
    check_eq("ret_irq_ack", {28'h0, irq_ack}, 32'h8);
    check_eq("ret_irq_vec", {16'h0, pc_next}, 32'h001C);
    rd_cr(3'd3, 16'h0040, "ret_irq_epc");
    ret = 1'b0; irq = 4'b0000;
    step();
    rd_cr(3'd0, 16'h0002, "isr_status");

    ret = 1'b1;
    run_instr();
    ret = 1'b0;
    check_eq("ret_pc", {16'h0, pc_next}, 32'h0040);
    rd_cr(3'd0, 16'h0001, "ret_ie");
    check_eq("ret_isr_clr", {31'h0, irq_active}, 32'h0);

    // ret and EPC write together: ret takes old EPC
    ret = 1'b1; cr_write = 1'b1; selector = 3'd3; r6_r7_data = 16'h0100;
    run_instr();
    ret = 1'b0; cr_write = 1'b0;
    check_eq("ret_old_epc", {16'h0, pc_next}, 32'h0040);
    rd_cr(3'd3, 16'h0100, "epc_written");

    // STATUS write alongside IRQ entry: IRQ's bits win
    cr_write = 1'b1; selector = 3'd0; r6_r7_data = 16'h0001; irq = 4'b0010;
    run_instr();
    check_eq("sw_irq_ack", {28'h0, irq_ack}, 32'h2);
    cr_write = 1'b0; irq = 4'b0000;
    step();
    rd_cr(3'd0, 16'h0002, "sw_irq_status");
    ret = 1'b1;
    run_instr();
    ret = 1'b0;
    check_eq("sw_ret_pc", {16'h0, pc_next}, 32'h0041);

    // asynchronous reset during MEMWAIT
    jmp = 1'b1; r6_r7_data = 16'h0100;
    run_instr();
    jmp = 1'b0;
    mem_write = 1'b1; mem_ok = 1'b0;
    step();
    step();
    check_eq("pre_rst_pc", {16'h0, pc_next}, 32'h0100);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_pc", {16'h0, pc_next}, 32'h0);
    check_eq("arst_ms", {31'h0, main_state}, 32'h0);
    check_eq("arst_ack", {28'h0, irq_ack}, 32'h0);
    check_eq("arst_isr", {31'h0, irq_active}, 32'h0);
    rd_cr(3'd0, 16'h0000, "arst_status");
    rd_cr(3'd1, 16'h0000, "arst_imask");
    rd_cr(3'd3, 16'h0000, "arst_epc");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
